// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_REQ,
        DM_DONE
    } dm_state_t;

    localparam int          DM_DEFAULT_TIMEOUT = 15;
    localparam logic [63:0] DM_ABORT_DATA      = '0;

    function automatic logic is_word_aligned(input logic [1:0] byte_offset);
        return byte_offset == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Counts cycles spent waiting for mem_ack; hit flags the last permitted wait cycle.
module dmem_timeout_ctr #(
    parameter  int TIMEOUT = 15,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic hit
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign hit = en && (count == LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage controller: issues one word access per load/store over a req/ack handshake
// and stalls the pipeline until the access completes, faults, or times out.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DM_DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic              MemtoRegM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    dm_state_t state, state_nxt;
    logic      acc;
    logic      aligned;
    logic      to_en;
    logic      to_clr;
    logic      to_hit;

    assign acc     = MemWriteM | MemtoRegM;
    assign aligned = is_word_aligned(ALUResultM[1:0]);
    assign to_en   = (state == DM_REQ);
    assign to_clr  = to_en && (mem_ack || to_hit);

    dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .en    (to_en),
        .clr   (to_clr),
        .hit   (to_hit)
    );

    // StallM comes from state and the MEM-stage inputs only, never from mem_rdata/mem_ack.
    always_comb begin
        // NOTE: defaults first so every path assigns each output and no latch is inferred.
        state_nxt = state;
        StallM    = 1'b0;
        case (state)
            DM_IDLE: begin
                StallM = acc;
                if (acc) begin
                    state_nxt = aligned ? DM_REQ : DM_DONE;
                end
            end
            DM_REQ: begin
                StallM = 1'b1;
                if (mem_ack || to_hit) begin
                    state_nxt = DM_DONE;
                end
            end
            DM_DONE: state_nxt = DM_IDLE;
            default: state_nxt = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DM_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ReadDataM <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                DM_IDLE: begin
                    if (acc && aligned) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;  // a store wins when both strobes are set
                        mem_addr  <= {ALUResultM[DATA_W-1:2], 2'b00};
                        mem_wdata <= WriteDataM;
                    end else if (acc) begin
                        err <= 1'b1;
                    end
                end
                DM_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ReadDataM <= mem_rdata;
                        end
                    end else if (to_hit) begin
                        mem_req   <= 1'b0;
                        err       <= 1'b1;
                        ReadDataM <= DATA_W'(DM_ABORT_DATA);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed reset/fault cases, then random loads/stores.
module tb_dmem_access_ctrl;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              MemWriteM = 1'b0;
    logic              MemtoRegM = 1'b0;
    logic [DATA_W-1:0] ALUResultM = '0;
    logic [DATA_W-1:0] WriteDataM = '0;
    logic [DATA_W-1:0] ReadDataM;
    logic              StallM;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              err;

    // Memory-side drive: directed values early on, the responder afterwards.
    logic              resp_en = 1'b0;
    logic              d_ack = 1'b0, r_ack = 1'b0;
    logic [DATA_W-1:0] d_rdata = '0, r_rdata = '0;
    assign mem_ack   = resp_en ? r_ack   : d_ack;
    assign mem_rdata = resp_en ? r_rdata : d_rdata;

    dmem_access_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stall;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic [31:0] m_rd = '0;
    logic        m_err = 1'b0;
    bit          abort = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one access costs 1 stall cycle (fault), ack latency + 1, or TIMEOUT + 1.
    task automatic run_txn(input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rdat, input int lat);
        exp_t e;
        req_t q;
        bit   done = 1'b0;
        if (a[1:0] != 2'b00) begin
            m_err   = 1'b1;
            e.stall = 1;
        end else begin
            q.we = w; q.addr = {a[31:2], 2'b00}; q.wdata = wd; q.rdata = rdat; q.lat = lat;
            req_q.push_back(q);
            if (lat <= TIMEOUT) begin
                e.stall = lat + 1;
                if (!w) m_rd = rdat;
            end else begin
                e.stall = TIMEOUT + 1;
                m_err   = 1'b1;
                m_rd    = '0;
            end
        end
        e.rd  = m_rd;
        e.err = m_err;
        exp_q.push_back(e);
        MemWriteM = w; MemtoRegM = r; ALUResultM = a; WriteDataM = wd;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!StallM) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            check("stall_release", {31'd0, StallM}, 32'd0);
            abort = 1'b1;
        end
        cyc();
        MemWriteM = 1'b0; MemtoRegM = 1'b0;
        ALUResultM = $urandom; WriteDataM = $urandom;
    endtask

    // Monitor: counts stall cycles of each access and compares when the access completes.
    int stall_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if ((MemWriteM | MemtoRegM) && StallM) begin
                    stall_cnt++;
                end else if (MemWriteM | MemtoRegM) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", {31'd0, StallM}, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("stall_cycles", stall_cnt, e.stall);
                        check("read_data", ReadDataM, e.rd);
                        check("err_flag", {31'd0, err}, {31'd0, e.err});
                    end
                    stall_cnt = 0;
                end else begin
                    check("idle_stall", {31'd0, StallM}, 32'd0);
                    check("idle_req", {31'd0, mem_req}, 32'd0);
                end
            end
        end
    end

    // Memory responder: checks request fields every REQ cycle and acks after the chosen latency.
    req_t cur;
    int   rcnt = 0;
    bit   have = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en) begin
                if (mem_req) begin
                    if (rcnt == 0) begin
                        have = (req_q.size() != 0);
                        if (have) cur = req_q.pop_front();
                        else check("unexpected_req", {31'd0, mem_req}, 32'd0);
                    end
                    rcnt++;
                    if (have) begin
                        check("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
                        check("mem_addr", mem_addr, cur.addr);
                        if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                    end
                    r_ack   = have && (rcnt == cur.lat);
                    r_rdata = r_ack ? cur.rdata : $urandom;
                end else begin
                    if (rcnt != 0 && have)
                        check("req_cycles", rcnt, (cur.lat <= TIMEOUT) ? cur.lat : TIMEOUT);
                    rcnt    = 0;
                    r_ack   = ($urandom_range(0, 3) == 0);  // spurious acks outside REQ
                    r_rdata = $urandom;
                end
            end
        end
    end

    initial begin
        repeat (3) cyc();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_read_data", ReadDataM, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall", {31'd0, StallM}, 32'd0);
        reset = 1'b0;

        // Load at 0x80 acked on the first REQ cycle.
        MemtoRegM = 1'b1; ALUResultM = 32'h80;
        cyc();
        check("ld_req", {31'd0, mem_req}, 32'd1);
        check("ld_addr", mem_addr, 32'h80);
        d_ack = 1'b1; d_rdata = 32'h5A5A_1234;
        cyc();
        d_ack = 1'b0;
        check("ld_rdata", ReadDataM, 32'h5A5A_1234);
        check("ld_done_stall", {31'd0, StallM}, 32'd0);
        check("ld_done_req", {31'd0, mem_req}, 32'd0);
        cyc();
        MemtoRegM = 1'b0;

        // Misaligned load: one stall cycle, sticky err, no request.
        MemtoRegM = 1'b1; ALUResultM = 32'h3;
        #1 check("mis_stall", {31'd0, StallM}, 32'd1);
        cyc();
        check("mis_err", {31'd0, err}, 32'd1);
        check("mis_req", {31'd0, mem_req}, 32'd0);
        check("mis_rdata", ReadDataM, 32'h5A5A_1234);
        cyc();
        MemtoRegM = 1'b0;

        // Spurious ack in IDLE.
        d_ack = 1'b1;
        cyc();
        d_ack = 1'b0;
        check("spur_req", {31'd0, mem_req}, 32'd0);
        check("spur_stall", {31'd0, StallM}, 32'd0);

        // Reset in the second REQ cycle, then a late ack.
        MemtoRegM = 1'b1; ALUResultM = 32'h40;
        cyc();
        cyc();
        check("rq2_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        cyc();
        check("rstmid_req", {31'd0, mem_req}, 32'd0);
        reset = 1'b0; MemtoRegM = 1'b0;
        d_ack = 1'b1; d_rdata = 32'hDEAD_BEEF;
        cyc();
        d_ack = 1'b0;
        check("late_ack_req", {31'd0, mem_req}, 32'd0);
        check("late_ack_stall", {31'd0, StallM}, 32'd0);
        check("late_ack_rdata", ReadDataM, 32'd0);
        check("late_ack_err", {31'd0, err}, 32'd0);
        check("late_ack_addr", mem_addr, 32'd0);
        check("late_ack_we", {31'd0, mem_we}, 32'd0);

        // Scoreboarded phase.
        m_rd = '0; m_err = 1'b0;
        resp_en = 1'b1; mon_en = 1'b1;
        cyc();
        run_txn(1'b0, 1'b1, 32'h100, $urandom, 32'hCAFE_F00D, 1);
        run_txn(1'b1, 1'b0, 32'h204, 32'h1234_5678, $urandom, 4);
        run_txn(1'b1, 1'b1, 32'h10, 32'hA5A5_0F0F, $urandom, 2);
        run_txn(1'b0, 1'b1, 32'h300, $urandom, $urandom, TIMEOUT + 3);
        run_txn(1'b0, 1'b1, 32'h103, $urandom, $urandom, 1);
        run_txn(1'b0, 1'b1, 32'h400, $urandom, 32'h0BAD_CAFE, TIMEOUT);
        for (int n = 0; n < 250 && !abort; n++) begin
            int          kind, sel, lat;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 2);
            a    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if (kind == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (kind == 1)      lat = $urandom_range(TIMEOUT + 1, TIMEOUT + 4);
            else if (kind == 2) lat = TIMEOUT;
            else                lat = $urandom_range(1, 6);
            run_txn(sel != 0, sel != 1, a, $urandom, $urandom, lat);
            repeat ($urandom_range(0, 2)) cyc();
        end
        repeat (3) cyc();
        check("exp_q_left", exp_q.size(), 32'd0);
        check("req_q_left", req_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
